// File: rtl/hvtx_pkg.sv
// Shared definitions for the HVTX TMDS receive/demodulation path.
//   - TMDS control-token code words and their 2-bit control values
//   - per-channel alignment state encoding
//   - channel-to-colour byte mapping for the recovered pixel
//   - tmds_decode(): 10-bit data symbol -> 8-bit pixel byte
package hvtx_pkg;

   localparam logic [9:0] TOK_CTL0 = 10'b1101010100;
   localparam logic [9:0] TOK_CTL1 = 10'b0010101011;
   localparam logic [9:0] TOK_CTL2 = 10'b0101010100;
   localparam logic [9:0] TOK_CTL3 = 10'b1010101011;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_LOCKED = 2'd3
   } align_state_e;

   // Channel index feeding each colour byte of the pixel (byte n = bits [8n+7:8n]).
   localparam int CH_BLUE  = 0;
   localparam int CH_GREEN = 1;
   localparam int CH_RED   = 2;
   localparam int NUM_CH   = 3;

   // q[9] undoes the optional inversion, q[8] selects XOR vs XNOR chaining.
   function automatic logic [7:0] tmds_decode(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] res;
      d      = q[9] ? ~q[7:0] : q[7:0];
      res    = '0;
      res[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         res[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return res;
   endfunction

endpackage

// File: rtl/hvtx_tmds_align.sv
// One TMDS channel: control-token detector, data decoder and word-alignment FSM.
// Ports:
//   i_clk, i_rst_n  pixel clock, async active-low reset
//   sym             10-bit word from the deserializer (bit 0 first on the wire)
//   bitslip         one-cycle request to shift the deserializer by one bit
//   chan_locked     registered alignment status
//   tok_q           registered: sym was a control token
//   val_q           registered: control value (in [1:0]) for a token, else decoded byte
//
// state     | meaning
// ST_SEARCH | counting consecutive tokens; window counter runs every cycle
// ST_SLIP   | bitslip pulse high for this single cycle
// ST_WAIT   | deserializer settling, input ignored for SLIP_WAIT cycles
// ST_LOCKED | aligned; window counter restarts on every token
module hvtx_tmds_align
   import hvtx_pkg::*;
#(
   parameter int LOCK_RUN      = 8,
   parameter int SEARCH_WINDOW = 4096,
   parameter int SLIP_WAIT     = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [9:0] sym,
   output logic       bitslip,
   output logic       chan_locked,
   output logic       tok_q,
   output logic [7:0] val_q
);

   localparam int RUN_W  = $clog2(LOCK_RUN) + 1;
   localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
   localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

   localparam logic [RUN_W-1:0]  RUN_TC  = RUN_W'(LOCK_RUN);
   localparam logic [WIN_W-1:0]  WIN_TC  = WIN_W'(SEARCH_WINDOW);
   localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(SLIP_WAIT);

   align_state_e      state, state_nx;
   logic [RUN_W-1:0]  run_cnt, run_nx, run_inc;
   logic [WIN_W-1:0]  win_cnt, win_nx, win_inc;
   logic [WAIT_W-1:0] wait_cnt, wait_nx, wait_inc;
   logic              sym_tok;
   logic [1:0]        sym_ctrl;

   always_comb begin
      sym_tok  = 1'b1;
      sym_ctrl = 2'b00;
      case (sym)
         TOK_CTL0: sym_ctrl = 2'b00;
         TOK_CTL1: sym_ctrl = 2'b01;
         TOK_CTL2: sym_ctrl = 2'b10;
         TOK_CTL3: sym_ctrl = 2'b11;
         default:  sym_tok  = 1'b0;
      endcase
   end

   // Saturating increments; a non-token breaks the run.
   always_comb begin
      win_inc  = (win_cnt == '1) ? win_cnt : win_cnt + 1'b1;
      wait_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
      run_inc  = '0;
      if (sym_tok) begin
         run_inc = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      run_nx   = run_cnt;
      win_nx   = win_cnt;
      wait_nx  = wait_cnt;
      case (state)
         ST_SEARCH: begin
            run_nx = run_inc;
            win_nx = win_inc;
            // A completed run wins over a window expiry in the same cycle.
            if (run_inc >= RUN_TC) begin
               state_nx = ST_LOCKED;
               run_nx   = '0;
               win_nx   = '0;
            end else if (win_inc >= WIN_TC) begin
               state_nx = ST_SLIP;
            end
         end
         ST_SLIP: begin
            state_nx = ST_WAIT;
            wait_nx  = '0;
         end
         ST_WAIT: begin
            wait_nx = wait_inc;
            if (wait_inc >= WAIT_TC) begin
               state_nx = ST_SEARCH;
               run_nx   = '0;
               win_nx   = '0;
               wait_nx  = '0;
            end
         end
         ST_LOCKED: begin
            win_nx = sym_tok ? '0 : win_inc;
            // Losing tokens drops back to search without slipping.
            if (!sym_tok && (win_inc >= WIN_TC)) begin
               state_nx = ST_SEARCH;
               run_nx   = '0;
               win_nx   = '0;
            end
         end
         default: state_nx = ST_SEARCH;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_SEARCH;
         run_cnt     <= '0;
         win_cnt     <= '0;
         wait_cnt    <= '0;
         bitslip     <= 1'b0;
         chan_locked <= 1'b0;
      end else begin
         state       <= state_nx;
         run_cnt     <= run_nx;
         win_cnt     <= win_nx;
         wait_cnt    <= wait_nx;
         bitslip     <= (state_nx == ST_SLIP);
         chan_locked <= (state_nx == ST_LOCKED);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tok_q <= 1'b0;
         val_q <= '0;
      end else begin
         tok_q <= sym_tok;
         val_q <= sym_tok ? {6'b0, sym_ctrl} : tmds_decode(sym);
      end
   end

endmodule

// File: rtl/hvtx_demod.sv
// HVTX TMDS demodulator top: three channel aligners, lock AND, sync hold and
// the output register stage (input-to-output latency of two cycles).
// Ports:
//   i_clk, i_rst_n  pixel clock, async active-low reset
//   i_chan_vec      [2:0][9:0] deserialized TMDS words, one per channel
//   o_bitslip       per-channel one-cycle bitslip request
//   o_chan_locked   per-channel alignment status
//   o_locked        all channels aligned
//   o_hs, o_vs      sync recovered from channel 0 control tokens, held during data
//   o_de            data enable (channel 0 carrying data while locked)
//   o_video         recovered pixel {ch2, ch1, ch0}, zero outside data periods
module hvtx_demod
   import hvtx_pkg::*;
#(
   parameter int LOCK_RUN      = 8,
   parameter int SEARCH_WINDOW = 4096,
   parameter int SLIP_WAIT     = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [2:0][9:0] i_chan_vec,
   output logic [2:0]      o_bitslip,
   output logic [2:0]      o_chan_locked,
   output logic            o_locked,
   output logic            o_hs,
   output logic            o_vs,
   output logic            o_de,
   output logic [23:0]     o_video
);

   logic [NUM_CH-1:0]      ch_tok;
   logic [NUM_CH-1:0][7:0] ch_val;
   logic [23:0]            pix_nx;
   logic [23:0]            video_q;
   logic                   de_q;
   logic [1:0]             sync_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      hvtx_tmds_align #(
         .LOCK_RUN      (LOCK_RUN),
         .SEARCH_WINDOW (SEARCH_WINDOW),
         .SLIP_WAIT     (SLIP_WAIT)
      ) u_align (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .sym         (i_chan_vec[g]),
         .bitslip     (o_bitslip[g]),
         .chan_locked (o_chan_locked[g]),
         .tok_q       (ch_tok[g]),
         .val_q       (ch_val[g])
      );
   end

   // A token byte carries no pixel data, so it never leaks into the video bus.
   always_comb begin
      pix_nx = {ch_tok[CH_RED]   ? 8'h00 : ch_val[CH_RED],
                ch_tok[CH_GREEN] ? 8'h00 : ch_val[CH_GREEN],
                ch_tok[CH_BLUE]  ? 8'h00 : ch_val[CH_BLUE]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         de_q    <= 1'b0;
         video_q <= '0;
         sync_q  <= '0;
      end else begin
         de_q    <= ~ch_tok[CH_BLUE];
         video_q <= ch_tok[CH_BLUE] ? 24'h000000 : pix_nx;
         if (ch_tok[CH_BLUE]) begin
            sync_q <= ch_val[CH_BLUE][1:0];
         end
      end
   end

   // Lock gating is applied after the registers so outputs are forced low in
   // the same cycle any channel loses alignment.
   assign o_locked = &o_chan_locked;
   assign o_de     = o_locked & de_q;
   assign o_video  = o_locked ? video_q : 24'h000000;
   assign o_hs     = o_locked & sync_q[0];
   assign o_vs     = o_locked & sync_q[1];

endmodule

// File: tb/tb_hvtx_demod.sv
module tb_hvtx_demod;

   localparam int LOCK_RUN      = 8;
   localparam int SEARCH_WINDOW = 4096;
   localparam int SLIP_WAIT     = 16;
   localparam logic [9:0] TK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic [2:0][9:0] i_chan_vec = '0;
   logic [2:0]      o_bitslip;
   logic [2:0]      o_chan_locked;
   logic            o_locked, o_hs, o_vs, o_de;
   logic [23:0]     o_video;

   hvtx_demod #(
      .LOCK_RUN      (LOCK_RUN),
      .SEARCH_WINDOW (SEARCH_WINDOW),
      .SLIP_WAIT     (SLIP_WAIT)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_chan_vec    (i_chan_vec),
      .o_bitslip     (o_bitslip),
      .o_chan_locked (o_chan_locked),
      .o_locked      (o_locked),
      .o_hs          (o_hs),
      .o_vs          (o_vs),
      .o_de          (o_de),
      .o_video       (o_video)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: per-channel alignment bookkeeping from the protocol rules.
   bit  m_locked [3];
   bit  m_slip   [3];
   int  m_settle [3];
   int  m_age    [3];
   int  m_run    [3];
   int  m_quiet  [3];
   // Words sampled one edge ago (the pipeline stage feeding the outputs).
   bit          p_tok;
   logic [1:0]  p_ctrl;
   logic [23:0] p_pix;
   logic [1:0]  e_sync;
   // Deserializer model for channel 1.
   int  rot1 = 0;
   bit  slip_seen = 0;
   int  de_seen = 0;
   int  bs_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_tok(input logic [9:0] w);
      for (int i = 0; i < 4; i++) if (w == TK[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] tok_val(input logic [9:0] w);
      for (int i = 0; i < 4; i++) if (w == TK[i]) return 2'(i);
      return 2'b00;
   endfunction

   // Transition-minimised encoder with random XOR/XNOR and inversion choice.
   function automatic logic [9:0] enc(input logic [7:0] b);
      logic [7:0] qm;
      logic       q8, q9;
      logic [9:0] w;
      q8    = 1'($urandom_range(0, 1));
      q9    = 1'($urandom_range(0, 1));
      qm[0] = b[0];
      for (int i = 1; i < 8; i++) qm[i] = q8 ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
      w = {q9, q8, q9 ? ~qm : qm};
      if (is_tok(w)) w = {~w[9], w[8], ~w[7:0]};
      return w;
   endfunction

   function automatic logic [9:0] rotr(input logic [9:0] w, input int r);
      logic [19:0] t;
      t = {w, w} >> r;
      return t[9:0];
   endfunction

   function automatic logic [2:0][9:0] blank(input int c);
      logic [2:0][9:0] v;
      v[0] = TK[c];
      v[1] = TK[0];
      v[2] = TK[0];
      return v;
   endfunction

   function automatic logic [2:0][9:0] pixel(input logic [23:0] p);
      logic [2:0][9:0] v;
      v[0] = enc(p[7:0]);
      v[1] = enc(p[15:8]);
      v[2] = enc(p[23:16]);
      return v;
   endfunction

   function automatic bit all_locked();
      return m_locked[0] && m_locked[1] && m_locked[2];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         m_locked[c] = 0; m_slip[c] = 0; m_settle[c] = 0;
         m_age[c] = 0; m_run[c] = 0; m_quiet[c] = 0;
      end
      p_tok = 0; p_ctrl = 2'b00; p_pix = '0; e_sync = 2'b00;
   endtask

   task automatic model_ch(input int c, input bit t);
      if (m_slip[c]) begin
         m_slip[c]   = 0;
         m_settle[c] = SLIP_WAIT;
      end else if (m_settle[c] > 0) begin
         m_settle[c]--;
         if (m_settle[c] == 0) begin m_age[c] = 0; m_run[c] = 0; end
      end else if (m_locked[c]) begin
         m_quiet[c] = t ? 0 : m_quiet[c] + 1;
         if (m_quiet[c] >= SEARCH_WINDOW) begin
            m_locked[c] = 0; m_age[c] = 0; m_run[c] = 0;
         end
      end else begin
         m_run[c] = t ? m_run[c] + 1 : 0;
         m_age[c]++;
         if (m_run[c] >= LOCK_RUN) begin
            m_locked[c] = 1; m_quiet[c] = 0;
         end else if (m_age[c] >= SEARCH_WINDOW) begin
            m_slip[c] = 1;
         end
      end
   endtask

   // Apply one word per channel, clock it, then compare every output.
   task automatic step(input logic [2:0][9:0] v_in, input logic [23:0] pix);
      logic [2:0][9:0] v;
      logic [2:0]      tk;
      bit              l;
      if (slip_seen && rot1 > 0) rot1--;
      v = v_in;
      if (rot1 != 0) v[1] = rotr(v[1], rot1);
      i_chan_vec = v;
      @(posedge i_clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         tk[c] = is_tok(v[c]);
         model_ch(c, tk[c]);
      end
      if (p_tok) e_sync = p_ctrl;
      l = all_locked();
      chk("chan_locked", 32'(o_chan_locked), 32'({m_locked[2], m_locked[1], m_locked[0]}));
      chk("bitslip", 32'(o_bitslip), 32'({m_slip[2], m_slip[1], m_slip[0]}));
      chk("locked", 32'(o_locked), 32'(l));
      chk("de", 32'(o_de), 32'(l && !p_tok));
      chk("video", 32'(o_video), (l && !p_tok) ? 32'(p_pix) : 32'h0);
      chk("sync", 32'({o_vs, o_hs}), l ? 32'(e_sync) : 32'h0);
      p_tok     = tk[0];
      p_ctrl    = tok_val(v[0]);
      p_pix     = pix;
      slip_seen = o_bitslip[1];
      if (o_de) de_seen++;
      bs_total += $countones(o_bitslip);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bitslip"}, 32'(o_bitslip), 32'h0);
      chk({tag, "_chan_locked"}, 32'(o_chan_locked), 32'h0);
      chk({tag, "_locked"}, 32'(o_locked), 32'h0);
      chk({tag, "_de"}, 32'(o_de), 32'h0);
      chk({tag, "_video"}, 32'(o_video), 32'h0);
      chk({tag, "_sync"}, 32'({o_vs, o_hs}), 32'h0);
   endtask

   task automatic do_reset();
      i_rst_n    = 1'b0;
      i_chan_vec = '0;
      model_reset();
      slip_seen  = 0;
      repeat (2) begin
         @(posedge i_clk);
         #1;
         chk_all_zero("reset");
      end
      i_rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int bs0;
      logic [23:0] px;
      logic [2:0][9:0] v;

      // Reset state, then 7 tokens / 1 data / 8 tokens: only the final run locks.
      do_reset();
      repeat (7) step(blank(0), 24'h0);
      step(pixel(24'h123456), 24'h123456);
      chk("no_lock_after_broken_run", 32'(o_locked), 32'h0);
      repeat (7) step(blank(0), 24'h0);
      chk("no_lock_at_7_of_run", 32'(o_locked), 32'h0);
      step(blank(0), 24'h0);
      chk("lock_at_8_of_run", 32'(o_locked), 32'h1);

      // Two 2200-cycle lines: hsync tokens, blanking, 1920 active pixels.
      de_seen = 0;
      for (int line = 0; line < 2; line++) begin
         repeat (44) step(blank(1), 24'h0);
         repeat (236) step(blank(0), 24'h0);
         for (int i = 0; i < 1920; i++) begin
            case (i % 3)
               0:       px = 24'h00f0f0;
               1:       px = 24'hc0c0c0;
               default: px = 24'($urandom);
            endcase
            step(pixel(px), px);
         end
      end
      repeat (2) step(blank(0), 24'h0);
      chk("de_cycles_two_lines", 32'(de_seen), 32'd3840);

      // vsync token then data: sync must hold through the data period.
      repeat (4) step(blank(2), 24'h0);
      for (int i = 0; i < 50; i++) begin
         px = 24'($urandom);
         step(pixel(px), px);
      end
      chk("vs_held", 32'(o_vs), 32'h1);
      chk("hs_held", 32'(o_hs), 32'h0);
      chk("de_in_data", 32'(o_de), 32'h1);

      // Channel 2 loses tokens while locked: drop after exactly the window, no slip.
      repeat (4) step(blank(0), 24'h0);
      bs0 = bs_total;
      for (int i = 0; i < SEARCH_WINDOW - 1; i++) begin
         v    = blank(0);
         v[2] = enc(8'($urandom));
         step(v, 24'h0);
      end
      chk("ch2_still_locked", 32'(o_chan_locked[2]), 32'h1);
      v    = blank(0);
      v[2] = enc(8'($urandom));
      step(v, 24'h0);
      chk("ch2_dropped", 32'(o_chan_locked[2]), 32'h0);
      chk("locked_dropped", 32'(o_locked), 32'h0);
      chk("de_dropped", 32'(o_de), 32'h0);
      chk("no_bitslip_on_drop", 32'(bs_total - bs0), 32'h0);
      repeat (8) step(blank(0), 24'h0);
      chk("ch2_relock", 32'(o_locked), 32'h1);

      // Channel 1 rotated by 3 bits: three slips, then lock.
      do_reset();
      rot1 = 3;
      bs0  = bs_total;
      n    = 0;
      while (!all_locked() && n < 20000) begin
         step(blank(0), 24'h0);
         n++;
      end
      chk("rot_locked", 32'(o_locked), 32'h1);
      chk("rot_slip_count", 32'(bs_total - bs0), 32'd3);

      // Reset pulsed during a slip cycle clears everything at once, then relock.
      do_reset();
      rot1 = 3;
      n    = 0;
      while (!m_slip[1] && n < 6000) begin
         step(blank(0), 24'h0);
         n++;
      end
      chk("in_slip_cycle", 32'(o_bitslip[1]), 32'h1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      do_reset();
      bs0 = bs_total;
      n   = 0;
      while (!all_locked() && n < 20000) begin
         step(blank(0), 24'h0);
         n++;
      end
      chk("relock_after_rst", 32'(o_locked), 32'h1);
      chk("relock_slip_count", 32'(bs_total - bs0), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hvtx_demod.md
HVTX_DEMOD -- requirements
Module: hvtx_demod

Interface
REQ-001 Parameter LOCK_RUN, default 8: consecutive control tokens required on a channel to declare it aligned.
REQ-002 Parameter SEARCH_WINDOW, default 4096: cycles without a qualifying token run before a bitslip, or before lock is dropped.
REQ-003 Parameter SLIP_WAIT, default 16: cycles ignored after each bitslip pulse while the deserializer settles.
REQ-004 i_clk  input  1  pixel clock, all logic on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_chan_vec  input  [2:0][9:0]  parallel TMDS words from the deserializer; bit 0 is the first serial bit.
REQ-007 o_bitslip  output  [2:0]  one-cycle bitslip request per channel.
REQ-008 o_chan_locked  output  [2:0]  per-channel alignment status.
REQ-009 o_locked  output  1  AND of o_chan_locked.
REQ-010 o_hs, o_vs, o_de  output  1 each  recovered sync and data-enable.
REQ-011 o_video  output  24  recovered pixel: [7:0] from channel 0, [15:8] from channel 1, [23:16] from channel 2.

Function
REQ-012 Control tokens shall be matched as follows: 1101010100 -> 00, 0010101011 -> 01, 0101010100 -> 10, 1010101011 -> 11.
REQ-013 Data symbols shall decode as follows:
- d = q[9] ? ~q[7:0] : q[7:0].
- out[0] = d[0].
- out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
REQ-014 Each channel shall run a state machine with states SEARCH, SLIP, WAIT and LOCKED.
REQ-015 In SEARCH, a run of LOCK_RUN consecutive tokens shall go to LOCKED; reaching SEARCH_WINDOW cycles shall go to SLIP.
REQ-016 SLIP shall assert that channel's o_bitslip for exactly one cycle and then enter WAIT.
REQ-017 WAIT shall last SLIP_WAIT cycles and then return to SEARCH with its window and run counters cleared.
REQ-018 Any non-token symbol in SEARCH shall clear the run counter but not the window counter.
REQ-019 In LOCKED, the window counter shall restart on every token.
REQ-020 If SEARCH_WINDOW cycles pass in LOCKED without a token, the channel shall drop to SEARCH with no bitslip issued.
REQ-021 Counters shall saturate and never wrap.
REQ-022 Counter widths shall be $clog2 of the corresponding parameter plus 1.
REQ-023 A window expiry and a completed token run in the same cycle shall resolve to LOCKED.
REQ-024 o_de shall be 1 when o_locked = 1 and the channel 0 symbol is not a control token.
REQ-025 On each channel 0 control token, {o_vs, o_hs} shall take the decoded token value.
REQ-026 During data periods, o_hs and o_vs shall hold their last values.
REQ-027 o_video shall be the decoded data when o_de = 1 and 24'h000000 otherwise.
REQ-028 While o_locked = 0, the outputs shall be forced as follows:
- o_de = 0.
- o_video = 0.
- o_hs and o_vs = 0.
REQ-029 Latency from i_chan_vec to o_hs, o_vs, o_de and o_video shall be exactly 2 cycles, with all four aligned.
REQ-030 o_chan_locked shall be registered.
REQ-031 o_chan_locked shall assert in the cycle after the LOCK_RUN-th token.
REQ-032 The block shall perform no inter-channel deskew; skew is bounded by the serializer and is out of scope.

Reset
REQ-033 On asserted i_rst_n, all channel state machines shall enter SEARCH with counters at 0.
REQ-034 During reset, all outputs shall be 0.
REQ-035 Reset asserted mid-operation, including in SLIP, shall clear o_bitslip in the same cycle.
REQ-036 Reset release shall restart the search with no residual pulse.

Structure
REQ-037 Package hvtx_pkg shall hold the four control-token constants, the state enum, and the channel-to-colour index constants.
REQ-038 Sub-module hvtx_tmds_align shall hold one channel's decoder, token detector and state machine.
REQ-039 hvtx_tmds_align shall be instantiated three times; the top level shall contain only the lock AND, the sync hold and the output registers.

Verification
REQ-040 Aligned feed from hvtx_mod at 1080p timing -> the following responses:
- o_locked rises within 1 line.
- o_video equals the transmitted 24'h00f0f0 and 24'hc0c0c0 pixels 2 cycles after input.
- o_de is high for 1920 cycles per line.
REQ-041 Channel 1 rotated by 3 bits with a model deserializer honouring bitslip -> after 3 slips, each 16 cycles apart following SEARCH_WINDOW expiries, channel 1 locks and o_locked = 1.
REQ-042 Tokens removed from channel 2 for 4096 cycles while locked -> o_chan_locked[2] and o_locked fall, and o_de = 0 with no bitslip issued.
REQ-043 Channel 0 token 0101010100 followed by data -> o_vs = 1 and o_hs = 0, held through the data period.
REQ-044 i_rst_n pulsed low during a SLIP cycle -> o_bitslip = 0 immediately, all outputs = 0, and relock succeeds after release.
REQ-045 7 tokens, 1 data word, then 8 tokens -> lock asserts only after the final 8-token run.
